// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and timing helpers shared by the UART transmit path
// and any future receive side.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state (8E1 frames).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } uart_state_t;

    // Clock cycles per line symbol, truncated.
    function automatic int symbol_edge_time(input int clock_freq, input int baud);
        return clock_freq / baud;
    endfunction

endpackage

// File: rtl/uart_symbol_timer.sv
// uart_symbol_timer: free-running 0..SYMBOL_EDGE_TIME-1 cycle counter that
// flags the last cycle of every symbol. A clear restarts the symbol at count 0.
module uart_symbol_timer #(
    parameter int SYMBOL_EDGE_TIME    = 10,
    parameter int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic symbol_done
);

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_COUNT =
        CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

    logic [CLOCK_COUNTER_WIDTH-1:0] count;

    // Count cycles within a symbol, wrapping at the symbol boundary.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign symbol_done = (count == LAST_COUNT);

endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: drains a synchronous-read FIFO and shifts each byte out as a
// UART frame, LSB first, idle-high line.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity symbol
// between the data bits and the stop bit.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ          = 125_000_000,
    parameter int BAUD_RATE           = 115_200,
    parameter int WIDTH               = 8,
    parameter int SYMBOL_EDGE_TIME    = symbol_edge_time(CLOCK_FREQ, BAUD_RATE),
    parameter int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             serial_out,
    output logic             busy
);

    localparam int BIT_CNT_W = $clog2(WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

    uart_state_t          state;
    uart_state_t          next_state;
    logic                 serial_next;
    logic                 symbol_done;
    logic [WIDTH-1:0]     shift_reg;
    logic [BIT_CNT_W-1:0] bit_cnt;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    uart_symbol_timer #(
        .SYMBOL_EDGE_TIME    (SYMBOL_EDGE_TIME),
        .CLOCK_COUNTER_WIDTH (CLOCK_COUNTER_WIDTH)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (state == LOAD),
        .symbol_done (symbol_done)
    );

    // State register and registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
        end else begin
            state      <= next_state;
            serial_out <= serial_next;
        end
    end

    // Next-state decode; serial_next is the line level for the coming cycle,
    // so the line is always driven straight from a flop.
    always_comb begin
        next_state  = state;
        serial_next = serial_out;
        fifo_rd_en  = 1'b0;
        case (state)
            IDLE: begin
                serial_next = 1'b1;
                if (enable && !fifo_empty) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                fifo_rd_en = 1'b1;
                next_state = LOAD;
            end
            LOAD: begin
                next_state  = START;
                serial_next = 1'b0;
            end
            START: begin
                if (symbol_done) begin
                    next_state  = DATA;
                    serial_next = shift_reg[0];
                end
            end
            DATA: begin
                if (symbol_done) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        next_state  = PARITY;
                        serial_next = parity_bit;
`else
                        next_state  = STOP;
                        serial_next = 1'b1;
`endif
                    end else begin
                        serial_next = shift_reg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (symbol_done) begin
                    next_state  = STOP;
                    serial_next = 1'b1;
                end
            end
`endif
            STOP: begin
                serial_next = 1'b1;
                if (symbol_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state  = IDLE;
                serial_next = 1'b1;
            end
        endcase
    end

    // Bit counter: cleared on capture, advanced at each data symbol boundary.
    always_ff @(posedge clk) begin
        if (rst || state == LOAD) begin
            bit_cnt <= '0;
        end else if (state == DATA && symbol_done) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Shift register capture (absorbs the FIFO read latency) and LSB-first shift.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            shift_reg  <= fifo_dout;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_dout;
`endif
        end else if (state == DATA && symbol_done) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: scoreboard bench for uart_fifo_tx with a behavioural
// synchronous-read FIFO. Frames are decoded from the line and compared with
// bytes queued at push time.
module tb_uart_fifo_tx;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int WIDTH      = 8;
    localparam int SET        = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NSYM = WIDTH + 3;
`else
    localparam int NSYM = WIDTH + 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             fifo_rd_en;
    logic             serial_out;
    logic             busy;

    logic [WIDTH-1:0] fifo_mem [0:15];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    int               rd_count = 0;
    int               cyc = 0;
    logic             underflow = 1'b0;
    logic [WIDTH-1:0] exp_q [$];
    int               checks = 0;
    int               errors = 0;

    uart_fifo_tx #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .WIDTH      (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .serial_out (serial_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Synchronous-read FIFO model plus cycle and read-strobe counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            if (wr_ptr == rd_ptr) underflow <= 1'b1;
            fifo_dout <= fifo_mem[rd_ptr[3:0]];
            rd_ptr    <= rd_ptr + 1;
            rd_count  <= rd_count + 1;
        end
    end

    task automatic push(input logic [WIDTH-1:0] b, input bit to_sb);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
        if (to_sb) exp_q.push_back(b);
    endtask

    // Waits (bounded) for a start bit, then samples every cycle of the frame.
    // ok clears if any symbol is not constant for SET cycles, or the start/stop
    // levels are wrong. Returns on the first cycle after the stop bit.
    task automatic recv_frame(output logic [WIDTH-1:0] data, output logic par,
                              output int t_start, output logic ok, output logic timeout);
        int   n;
        logic b;
        ok = 1'b1; timeout = 1'b0; data = '0; par = 1'b0; n = 0; t_start = 0;
        while (serial_out !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (serial_out !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        t_start = cyc;
        for (int s = 0; s < NSYM; s++) begin
            b = serial_out;
            for (int k = 0; k < SET; k++) begin
                if (serial_out !== b) ok = 1'b0;
                @(negedge clk);
            end
            if (s == 0 && b !== 1'b0) ok = 1'b0;
            if (s >= 1 && s <= WIDTH) data[s-1] = b;
            if (s == WIDTH + 1 && NSYM == WIDTH + 3) par = b;
            if (s == NSYM - 1 && b !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_serial_out got %b want 1", serial_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int c0, r0, ts;
        logic [WIDTH-1:0] d, e;
        logic p, ok, to;
        r0 = rd_count;
        push(8'hA5, 1'b1);
        enable = 1'b1;
        c0 = cyc;
        @(negedge clk);
        checks++;
        if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en_c1 got %b want 1", fifo_rd_en); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c1 got %b want 1", busy); end
        @(negedge clk);
        checks++;
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL single_rd_en_c2 got %b want 0", fifo_rd_en); end
        recv_frame(d, p, ts, ok, to);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout got no start bit want start bit"); return; end
        checks++;
        if (ts != c0 + 3) begin errors++; $display("FAIL single_start_cycle got %0d want %0d", ts - c0, 3); end
        checks++;
        if (!ok) begin errors++; $display("FAIL single_symbol_shape got bad want 10-cycle symbols"); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (d !== e) begin errors++; $display("FAIL single_data got %h want %h", d, e); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
        checks++;
        if (rd_count - r0 != 1) begin errors++; $display("FAIL single_reads got %0d want 1", rd_count - r0); end
    endtask

    task automatic test_back_to_back();
        int r0, ts1, ts2;
        logic [WIDTH-1:0] d, e;
        logic p, ok, to;
        r0 = rd_count;
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        enable = 1'b1;
        recv_frame(d, p, ts1, ok, to);
        checks++;
        if (to || !ok) begin errors++; $display("FAIL b2b_frame1 got to=%b ok=%b want to=0 ok=1", to, ok); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (d !== e) begin errors++; $display("FAIL b2b_data1 got %h want %h", d, e); end
        recv_frame(d, p, ts2, ok, to);
        checks++;
        if (to || !ok) begin errors++; $display("FAIL b2b_frame2 got to=%b ok=%b want to=0 ok=1", to, ok); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (d !== e) begin errors++; $display("FAIL b2b_data2 got %h want %h", d, e); end
        checks++;
        if (ts2 - (ts1 + SET * NSYM) != 3) begin
            errors++; $display("FAIL b2b_gap got %0d want 3", ts2 - (ts1 + SET * NSYM));
        end
        checks++;
        if (rd_count - r0 != 2) begin errors++; $display("FAIL b2b_reads got %0d want 2", rd_count - r0); end
        enable = 1'b0;
    endtask

    task automatic test_gating();
        int   r0, ts;
        logic bad_rd, bad_line, bad_busy;
        logic [WIDTH-1:0] d, e;
        logic p, ok, to;
        // Empty FIFO with enable high.
        enable = 1'b1; bad_rd = 1'b0; bad_line = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0) bad_rd = 1'b1;
            if (serial_out !== 1'b1) bad_line = 1'b1;
        end
        checks++;
        if (bad_rd) begin errors++; $display("FAIL empty_rd_en got strobe want none"); end
        checks++;
        if (bad_line) begin errors++; $display("FAIL empty_line got low want high"); end
        // Data present but enable low.
        enable = 1'b0; bad_rd = 1'b0; bad_busy = 1'b0;
        push(8'h5A, 1'b1);
        repeat (30) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0) bad_rd = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
        end
        checks++;
        if (bad_rd || bad_busy) begin errors++; $display("FAIL enable_low got rd=%b busy=%b want 0 0", bad_rd, bad_busy); end
        // Enable dropped inside a frame: that frame completes, nothing else is read.
        push(8'hC3, 1'b1);
        r0 = rd_count;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        recv_frame(d, p, ts, ok, to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (to || !ok || d !== e) begin
            errors++; $display("FAIL drop_frame got %h to=%b ok=%b want %h", d, to, ok, e);
        end
        bad_rd = 1'b0; bad_busy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0) bad_rd = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
        end
        checks++;
        if (bad_rd || bad_busy || rd_count - r0 != 1) begin
            errors++; $display("FAIL drop_no_more_reads got reads=%0d busy=%b want 1 0", rd_count - r0, bad_busy);
        end
        // Re-enable to drain the remaining byte.
        enable = 1'b1;
        recv_frame(d, p, ts, ok, to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (to || !ok || d !== e) begin
            errors++; $display("FAIL drain_frame got %h to=%b ok=%b want %h", d, to, ok, e);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int   r0;
        logic bad;
        r0 = rd_count;
        push(8'h3C, 1'b0);
        enable = 1'b1;
        repeat (55) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || serial_out !== 1'b1) begin
            errors++; $display("FAIL midrst_bit4 got busy=%b line=%b want 1 1", busy, serial_out);
        end
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL midrst_state got line=%b busy=%b rd=%b want 1 0 0", serial_out, busy, fifo_rd_en);
        end
        rst = 1'b0; bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || serial_out !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad || rd_count - r0 != 1) begin
            errors++; $display("FAIL midrst_after got reads=%0d activity=%b want 1 0", rd_count - r0, bad);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [WIDTH-1:0] bytes [2];
        logic             want_par [2];
        int               ts [2];
        logic [WIDTH-1:0] d, e;
        logic p, ok, to;
        bytes[0] = 8'h07; want_par[0] = 1'b1;
        bytes[1] = 8'h03; want_par[1] = 1'b0;
        push(bytes[0], 1'b1);
        push(bytes[1], 1'b1);
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            recv_frame(d, p, ts[i], ok, to);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (to || !ok || d !== e) begin
                errors++; $display("FAIL parity_frame%0d got %h to=%b ok=%b want %h", i, d, to, ok, e);
            end
            checks++;
            if (p !== want_par[i]) begin errors++; $display("FAIL parity_bit%0d got %b want %b", i, p, want_par[i]); end
        end
        checks++;
        if (ts[1] - ts[0] != 110 + 3) begin errors++; $display("FAIL parity_frame_len got %0d want 113", ts[1] - ts[0]); end
        enable = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gating();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL fifo_underflow got read of empty FIFO want none"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

Serial transmitter that drains bytes from a synchronous-read FIFO and shifts them out as 8N1 UART frames, LSB first. It sits on the FIFO's read side in the I/O path: the CPU's MMIO store fills the FIFO, and this block empties it onto the serial line. Pacing comes from a per-symbol clock-cycle counter derived from the clock frequency and baud rate.

## Interface
- CLOCK_FREQ, 125_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: line rate in symbols/s.
- WIDTH, 8: data bits per frame. Also the FIFO data width.
- SYMBOL_EDGE_TIME, CLOCK_FREQ/BAUD_RATE: cycles per symbol. Integer division, truncated. Must be >= 2.
- CLOCK_COUNTER_WIDTH, $clog2(SYMBOL_EDGE_TIME): symbol counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  permits starting a new frame. Sampled only in IDLE.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  WIDTH  FIFO read data. Valid the cycle after fifo_rd_en is sampled high.
- fifo_rd_en  out  1  FIFO read strobe.
- serial_out  out  1  UART line. Idle high.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP, plus PARITY when configured.
- IDLE: if enable & !fifo_empty, go to FETCH. Otherwise stay.
- FETCH: fifo_rd_en = 1, decoded from state, for exactly one cycle. Go to LOAD.
- LOAD: capture fifo_dout into the shift register, clear the symbol counter and bit counter. Go to START.
- START: serial_out = 0 for SYMBOL_EDGE_TIME cycles. Then go to DATA.
- DATA: serial_out = shift[0]. After each SYMBOL_EDGE_TIME cycles, shift right and increment the bit counter. After WIDTH bits, go to PARITY if configured, otherwise STOP.
- STOP: serial_out = 1 for SYMBOL_EDGE_TIME cycles. Then go to IDLE.
- The symbol counter counts 0..SYMBOL_EDGE_TIME-1 and wraps at the symbol boundary.
- The bit counter is $clog2(WIDTH+1) bits wide.
- serial_out is driven from a register, so it is glitch-free.
- fifo_empty is ignored outside IDLE. The block never reads an empty FIFO.
- Deasserting enable mid-frame does not abort the frame. The current frame completes, then the block holds in IDLE.

## Timing
- Reset values: serial_out=1, fifo_rd_en=0, busy=0, state=IDLE, counters=0.
- Reset asserted mid-frame: the next edge forces IDLE and serial_out=1. The in-flight byte is dropped, and no FIFO read is issued that cycle.
- Latency: the rising edge that samples IDLE with !fifo_empty is edge 0.
  - FETCH at cycle 1.
  - LOAD at cycle 2.
  - serial_out falls at cycle 3.
- Frame length: (2+WIDTH)·SYMBOL_EDGE_TIME cycles. With parity: (3+WIDTH)·SYMBOL_EDGE_TIME cycles.
- Back-to-back bytes: 3 idle-high cycles (IDLE, FETCH, LOAD) between the end of one stop bit and the next start bit.
- The FIFO's one-cycle read latency is absorbed by LOAD. No combinational path from fifo_dout to serial_out.

## Configuration
- UART_TX_PARITY_EN defined: a PARITY state follows DATA.
  - serial_out = even parity (XOR of the captured byte) for SYMBOL_EDGE_TIME cycles.
  - Parity is computed at LOAD.
- Undefined: 8N1. The PARITY state and the parity register are absent.

## Structure
- Package uart_pkg:
  - the state enum;
  - a symbol_edge_time(clock_freq, baud) constant function.
- Sub-module uart_symbol_timer: symbol counter with clear input and symbol_done output. Reusable by the receive side.

## Test plan
Sim parameters: CLOCK_FREQ=1000, BAUD_RATE=100, giving SYMBOL_EDGE_TIME=10.

- **Reset:** hold rst 3 cycles -> serial_out=1, busy=0, fifo_rd_en=0.
- **Single byte:** FIFO holds 0xA5, enable=1.
  - fifo_rd_en is high for exactly 1 cycle.
  - serial_out is 0 for cycles 3–12.
  - Data bits 1,0,1,0,0,1,0,1, 10 cycles each.
  - Stop bit is high for 10 cycles. busy drops after 100 frame cycles.
- **Back-to-back:** FIFO holds 0x00 then 0xFF.
  - Two frames separated by exactly 3 high cycles.
  - Second frame's data bits are all 1.
  - Exactly 2 read strobes total.
- **Empty/enable gating:**
  - fifo_empty=1 for 50 cycles -> no rd_en, serial_out=1.
  - enable=0 with a non-empty FIFO -> no rd_en.
  - Dropping enable mid-frame -> the frame completes, with no further reads.
- **Reset mid-frame:** assert rst during bit 4 of 0x3C -> serial_out=1 next cycle, busy=0. No further reads until re-enabled.
- **Parity (UART_TX_PARITY_EN):** 0x07 -> parity bit 1. 0x03 -> parity bit 0. Frame is 110 cycles.
